// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared state encoding, button indices and counter sizing helper
// Revision : 1.0
// ============================================================================
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_C = 4;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_chan.sv
`default_nettype none
// ============================================================================
// Module   : btn_chan
// Purpose  : One button: synchronizer, debounce, press/repeat FSM, sticky flag
// Revision : 1.0
// ============================================================================
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 15000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_raw,
  input  logic i_evt_ack,
  output logic o_level,
  output logic o_press,
  output logic o_repeat,
  output logic o_evt_pending
);

  localparam int c_dw = cnt_width(DEBOUNCE_CYCLES);
  localparam int c_hw = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [c_dw-1:0] c_db_last   = c_dw'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_hw-1:0] c_hold_last = c_hw'(HOLD_CYCLES - 1);
  localparam logic [c_hw-1:0] c_rep_last  = c_hw'(REPEAT_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [c_dw-1:0] r_db_cnt;
  logic            r_level;
  btn_state_e      r_state;
  logic [c_hw-1:0] r_hold_cnt;
  logic            r_press;
  logic            r_repeat;
  logic            r_evt;

  logic            w_mismatch;
  logic            w_accept;
  btn_state_e      w_state_nxt;
  logic [c_hw-1:0] w_hold_nxt;
  logic            w_press_nxt;
  logic            w_repeat_nxt;

  assign w_mismatch = r_sync2 ^ r_level;
  assign w_accept   = w_mismatch && (r_db_cnt == c_db_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      // Any cycle of agreement restarts the stability window.
      if (!w_mismatch || w_accept) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_dw'(1);
      end
      if (w_accept) begin
        r_level <= ~r_level;
      end
    end
  end

  // Transitions are judged on the same edge that flips the debounced level,
  // so btn_press lands in the first cycle btn_level reads 1.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_press_nxt  = 1'b0;
    w_repeat_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        w_hold_nxt = '0;
        if (w_accept && !r_level) begin
          w_state_nxt = HELD;
          w_press_nxt = 1'b1;
        end
      end
      HELD: begin
        if (w_accept && r_level) begin
          w_state_nxt = RELEASED;
          w_hold_nxt  = '0;
        end else if (REPEAT_EN && (r_hold_cnt == c_hold_last)) begin
          w_state_nxt  = REPEATING;
          w_hold_nxt   = '0;
          w_repeat_nxt = 1'b1;
        end else if (REPEAT_EN) begin
          w_hold_nxt = r_hold_cnt + c_hw'(1);
        end
      end
      REPEATING: begin
        if (w_accept && r_level) begin
          w_state_nxt = RELEASED;
          w_hold_nxt  = '0;
        end else if (r_hold_cnt == c_rep_last) begin
          w_hold_nxt   = '0;
          w_repeat_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + c_hw'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RELEASED;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_repeat   <= 1'b0;
      r_evt      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_press    <= w_press_nxt;
      r_repeat   <= w_repeat_nxt;
      if (r_press || r_repeat) begin
        r_evt <= 1'b1;
      end else if (i_evt_ack) begin
        r_evt <= 1'b0;
      end
    end
  end

  assign o_level       = r_level;
  assign o_press       = r_press;
  assign o_repeat      = r_repeat;
  assign o_evt_pending = r_evt;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Five independent conditioned push-button channels {C,U,D,L,R}
// Revision : 1.0
// ============================================================================
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 15000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] evt_pending,
  input  logic [N_BTN-1:0] evt_ack
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_btn_raw     (btn_raw[gi]),
      .i_evt_ack     (evt_ack[gi]),
      .o_level       (btn_level[gi]),
      .o_press       (btn_press[gi]),
      .o_repeat      (btn_repeat[gi]),
      .o_evt_pending (evt_pending[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Directed self-checking bench for btn_conditioner (short timings)
// Revision : 1.0
// ============================================================================
module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_repeat;
  logic [4:0] evt_pending;
  logic [4:0] evt_ack;

  int total = 0;
  int bad   = 0;

  btn_conditioner #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (5),
    .REPEAT_EN       (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_repeat  (btn_repeat),
    .evt_pending (evt_pending),
    .evt_ack     (evt_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle k is the interval just after clock edge k.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_raw = '0;
    repeat (12) tick();
    evt_ack = 5'h1f;
    tick();
    evt_ack = '0;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    evt_ack = '0;
    repeat (3) tick();
    check("rst_level",  btn_level,   5'h00);
    check("rst_press",  btn_press,   5'h00);
    check("rst_repeat", btn_repeat,  5'h00);
    check("rst_evt",    evt_pending, 5'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // Clean press on U: raw high for cycles 0..7.
    btn_raw[3] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("t1_press",  5'(btn_press[3]),   5'(i == 6));
      check("t1_level",  5'(btn_level[3]),   5'(i >= 6 && i < 14));
      check("t1_repeat", btn_repeat,         5'h00);
      check("t1_evt",    5'(evt_pending[3]), 5'(i >= 7));
      if (i == 8) btn_raw[3] = 1'b0;
    end
    evt_ack[3] = 1'b1;
    tick();
    evt_ack[3] = 1'b0;
    check("t1_ack", evt_pending, 5'h00);
    settle();

    // Bounce on L: raw 1,0,1,0 on cycles 0..3, then steady 1.
    btn_raw[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("t2_press", btn_press,        (i == 10) ? 5'h02 : 5'h00);
      check("t2_level", 5'(btn_level[1]), 5'(i >= 10));
      btn_raw[1] = !(i == 1 || i == 3);
    end
    settle();

    // Hold-repeat on R: raw high for cycles 0..39.
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      check("t3_press",  5'(btn_press[0]),  5'(i == 6));
      check("t3_repeat", 5'(btn_repeat[0]), 5'(i >= 16 && i <= 41 && ((i - 16) % 5) == 0));
      check("t3_level",  5'(btn_level[0]),  5'(i >= 6 && i < 46));
      btn_raw[0] = (i < 40);
    end
    settle();

    // Ack race on U: ack coincides with the first repeat, then a lone ack.
    btn_raw[3] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check("t4_repeat", 5'(btn_repeat[3]),  5'(i == 16 || i == 21));
      check("t4_evt",    5'(evt_pending[3]), 5'((i >= 7 && i < 18) || i >= 22));
      evt_ack[3] = (i == 16 || i == 17);
      btn_raw[3] = (i < 18);
    end
    evt_ack = '0;
    settle();

    // Reset mid-hold on C.
    btn_raw[4] = 1'b1;
    for (int i = 1; i <= 12; i++) tick();
    check("t5_pre_level", btn_level,   5'h10);
    check("t5_pre_evt",   evt_pending, 5'h10);
    rst_n = 1'b0;
    #1;
    check("t5_async_level", btn_level,   5'h00);
    check("t5_async_evt",   evt_pending, 5'h00);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t5_in_rst", btn_level | btn_press | btn_repeat | evt_pending, 5'h00);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("t5_press", btn_press,        (j == 6) ? 5'h10 : 5'h00);
      check("t5_level", 5'(btn_level[4]), 5'(j >= 6));
    end
    settle();

    // All five together.
    btn_raw = 5'h1f;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t6_press", btn_press,   (i == 6) ? 5'h1f : 5'h00);
      check("t6_evt",   evt_pending, (i >= 7) ? 5'h1f : 5'h00);
    end
    settle();
    check("t6_cleared", evt_pending, 5'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
